// File: rtl/jk_ff_checker_if.sv
// Signal bundle between a JK flop monitor harness and jk_ff_checker.
// The master side drives the observed nets; the checker drives results back.
interface jk_ff_checker_if #(
    parameter int CNT_W = 16
);
    logic             en_i;
    logic             clr_i;
    logic             j_i;
    logic             k_i;
    logic             q_i;
    logic             mismatch_o;
    logic             err_o;
    logic [1:0]       state_o;
    logic             exp_q_o;
    logic [CNT_W-1:0] cyc_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] first_err_o;
    logic [CNT_W-1:0] hold_cnt_o;
    logic [CNT_W-1:0] rst_cnt_o;
    logic [CNT_W-1:0] set_cnt_o;
    logic [CNT_W-1:0] tgl_cnt_o;

    modport master (
        output en_i, clr_i, j_i, k_i, q_i,
        input  mismatch_o, err_o, state_o, exp_q_o, cyc_cnt_o, err_cnt_o,
               first_err_o, hold_cnt_o, rst_cnt_o, set_cnt_o, tgl_cnt_o
    );

    modport slave (
        input  en_i, clr_i, j_i, k_i, q_i,
        output mismatch_o, err_o, state_o, exp_q_o, cyc_cnt_o, err_cnt_o,
               first_err_o, hold_cnt_o, rst_cnt_o, set_cnt_o, tgl_cnt_o
    );
endinterface

// File: rtl/jk_ff_checker.sv
// Cycle-accurate golden JK model beside the real flop: flags q mismatches and
// keeps saturating per-command statistics.
module jk_ff_checker #(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input logic             clk_i,
    input logic             rst_i,
    jk_ff_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             exp_q;
    logic             exp_nxt;
    logic             check;
    logic             miss;
    logic             mismatch;
    logic             err_flag;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err;
    logic [CNT_W-1:0] cls_cnt [4];
    logic [1:0]       cmd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cmd   = {bus.j_i, bus.k_i};
    // Both q_i and exp_q reflect the previous edge, so they compare directly.
    assign check = (state == CHECK) && bus.en_i && !bus.clr_i;
    assign miss  = check && (bus.q_i != exp_q);

    always_comb begin
        exp_nxt = exp_q;
        case (cmd)
            2'b00:   exp_nxt = exp_q;
            2'b01:   exp_nxt = 1'b0;
            2'b10:   exp_nxt = 1'b1;
            default: exp_nxt = ~exp_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.en_i) state_nxt = CHECK;
                CHECK: begin
                    if (!bus.en_i)              state_nxt = IDLE;
                    else if (STOP_ON_ERR && miss) state_nxt = HALT;
                end
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // The golden model tracks j/k on every edge so checking may start mid-run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_q     <= 1'b0;
            mismatch  <= 1'b0;
            err_flag  <= 1'b0;
            cyc_cnt   <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            for (int i = 0; i < 4; i++) cls_cnt[i] <= '0;
        end else begin
            exp_q <= exp_nxt;
            if (bus.clr_i) begin
                mismatch  <= 1'b0;
                err_flag  <= 1'b0;
                cyc_cnt   <= '0;
                err_cnt   <= '0;
                first_err <= '0;
                for (int i = 0; i < 4; i++) cls_cnt[i] <= '0;
            end else begin
                mismatch <= miss;
                if (check) begin
                    cyc_cnt      <= sat_inc(cyc_cnt);
                    cls_cnt[cmd] <= sat_inc(cls_cnt[cmd]);
                end
                if (miss) begin
                    err_flag <= 1'b1;
                    err_cnt  <= sat_inc(err_cnt);
                    if (!err_flag) first_err <= cyc_cnt;
                end
            end
        end
    end

    assign bus.mismatch_o  = mismatch;
    assign bus.err_o       = err_flag;
    assign bus.state_o     = state;
    assign bus.exp_q_o     = exp_q;
    assign bus.cyc_cnt_o   = cyc_cnt;
    assign bus.err_cnt_o   = err_cnt;
    assign bus.first_err_o = first_err;
    assign bus.hold_cnt_o  = cls_cnt[0];
    assign bus.rst_cnt_o   = cls_cnt[1];
    assign bus.set_cnt_o   = cls_cnt[2];
    assign bus.tgl_cnt_o   = cls_cnt[3];
endmodule
